// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file widths and typedefs shared with the decode and hazard units.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: combinational read of data and busy bit with write-to-read forwarding.
module regfile_read_port import cpu_pkg::*; #(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    mem_i [2**ADDR_W],
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  input  logic                 set_en_i,
  input  logic [ADDR_W-1:0]    set_addr_i,
  input  logic [2**ADDR_W-1:0] busy_i,
  output logic [DATA_W-1:0]    rdata_o,
  output logic                 busy_o
);
  logic is_zero, wr_hit, set_hit;
  // wr_en_i is already qualified: no reset and not a dropped zero-register write.
  always_comb begin
    is_zero = (ZERO_REG != 0) && (addr_i == ADDR_W'(REG_ZERO));
    wr_hit  = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr_i);
    set_hit = set_en_i && (set_addr_i == addr_i);
    rdata_o = is_zero ? '0 : wr_hit ? wr_data_i : mem_i[addr_i];
    busy_o  = busy_i[addr_i] && !(wr_hit && !set_hit);
  end
endmodule

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: 2-read/1-write register file with per-register pending-write scoreboard.
module regfile_2r1w_sb import cpu_pkg::*; #(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy_b,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              we_eff, set_eff;
  assign we_eff  = we && !reset && !((ZERO_REG != 0) && (waddr == ADDR_W'(REG_ZERO)));
  assign set_eff = sb_set && !reset && !((ZERO_REG != 0) && (sb_addr == ADDR_W'(REG_ZERO)));
  // Set beats clear on the same register: the new producer is still outstanding.
  for (genvar i = 0; i < DEPTH; i++) begin : g_busy
    assign busy_d[i] = (set_eff && (sb_addr == ADDR_W'(i))) || (busy_q[i] && !(we && (waddr == ADDR_W'(i))));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      busy_q <= '0;
    end else begin
      if (we_eff) mem_q[waddr] <= wdata;
      busy_q <= busy_d;
    end
  end
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_port_a (
    .addr_i(raddr_a), .mem_i(mem_q), .wr_en_i(we_eff), .wr_addr_i(waddr), .wr_data_i(wdata),
    .set_en_i(set_eff), .set_addr_i(sb_addr), .busy_i(busy_q), .rdata_o(rdata_a), .busy_o(busy_a)
  );
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_port_b (
    .addr_i(raddr_b), .mem_i(mem_q), .wr_en_i(we_eff), .wr_addr_i(waddr), .wr_data_i(wdata),
    .set_en_i(set_eff), .set_addr_i(sb_addr), .busy_i(busy_q), .rdata_o(rdata_b), .busy_o(busy_b)
  );
endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb_regfile_2r1w_sb: scoreboard bench for regfile_2r1w_sb with default parameters.
module tb_regfile_2r1w_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;
  logic clk = 1'b0;
  logic reset, we, sb_set, busy_a, busy_b;
  logic [AW-1:0] waddr, raddr_a, raddr_b, sb_addr;
  logic [DW-1:0] wdata, rdata_a, rdata_b;
  typedef struct packed {
    logic [DW-1:0] ra;
    logic          ba;
    logic [DW-1:0] rb;
    logic          bb;
  } exp_t;
  exp_t exp_q[$];
  logic [DW-1:0] m [N];
  logic [N-1:0]  b;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  regfile_2r1w_sb dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .busy_a(busy_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b), .busy_b(busy_b),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we && !reset && waddr == a) return wdata;
    return m[a];
  endfunction
  function automatic logic mbusy(input logic [AW-1:0] a);
    if (a != 0 && we && !reset && waddr == a && !(sb_set && sb_addr == a)) return 1'b0;
    return b[a];
  endfunction
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < N; i++) m[i] = '0;
      b = '0;
    end else begin
      if (we && waddr != 0) m[waddr] = wdata;
      if (we) b[waddr] = 1'b0;
      if (sb_set && sb_addr != 0) b[sb_addr] = 1'b1;
    end
  endtask
  task automatic cyc(input string tag);
    exp_t e;
    exp_q.push_back('{ra: mrd(raddr_a), ba: mbusy(raddr_a), rb: mrd(raddr_b), bb: mbusy(raddr_b)});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".rdata_a"}, rdata_a, e.ra);
    check({tag, ".busy_a"}, DW'(busy_a), DW'(e.ba));
    check({tag, ".rdata_b"}, rdata_b, e.rb);
    check({tag, ".busy_b"}, DW'(busy_b), DW'(e.bb));
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic idle();
    reset = 1'b0; we = 1'b0; sb_set = 1'b0;
  endtask
  initial begin
    idle();
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0; sb_addr = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) m[i] = '0;
    b = '0;
    raddr_a = 5'd3; raddr_b = 5'd31;
    cyc("reset");
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF; raddr_b = 5'd4;
    cyc("wr3");
    idle();
    cyc("rd3");
    check("lit_dead", rdata_a, 32'hDEADBEEF);
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr_a = 5'd7; raddr_b = 5'd7;
    cyc("bypass7");
    idle();
    cyc("rd7");
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; sb_set = 1'b1; sb_addr = 5'd0; raddr_a = 5'd0; raddr_b = 5'd0;
    cyc("zero_wr");
    idle();
    cyc("zero_rd");
    sb_set = 1'b1; sb_addr = 5'd9; raddr_a = 5'd9; raddr_b = 5'd3;
    cyc("set9");
    idle();
    cyc("busy9_a");
    cyc("busy9_b");
    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    cyc("clr9");
    idle();
    cyc("after9");
    check("lit_55", rdata_a, 32'h55);
    check("lit_busy9", DW'(busy_a), '0);
    sb_set = 1'b1; sb_addr = 5'd5; raddr_a = 5'd5; raddr_b = 5'd9;
    cyc("set5");
    we = 1'b1; waddr = 5'd5; wdata = 32'hAA; sb_set = 1'b1; sb_addr = 5'd5;
    cyc("setclr5");
    idle();
    cyc("after5");
    check("lit_busy5", DW'(busy_a), 1);
    for (int i = 1; i < N; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = DW'(i); raddr_a = AW'(i); raddr_b = AW'(i - 1);
      cyc("fill");
    end
    idle();
    sb_set = 1'b1; sb_addr = 5'd10; raddr_a = 5'd10; raddr_b = 5'd20;
    cyc("set10");
    sb_addr = 5'd20;
    cyc("set20");
    reset = 1'b1; we = 1'b1; waddr = 5'd10; wdata = 32'hBAD; sb_set = 1'b0;
    cyc("midreset");
    idle();
    for (int i = 0; i < N; i++) begin
      raddr_a = AW'(i); raddr_b = AW'(N - 1 - i);
      cyc("sweep");
    end
    we = 1'b1; waddr = 5'd12; wdata = 32'h77; raddr_a = 5'd12; raddr_b = 5'd10;
    cyc("postwr");
    idle();
    cyc("postrd");
    check("lit_77", rdata_a, 32'h77);
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      we = $urandom_range(0, 1) == 1;
      sb_set = $urandom_range(0, 1) == 1;
      waddr = AW'($urandom_range(0, 7));
      sb_addr = AW'($urandom_range(0, 7));
      raddr_a = AW'($urandom_range(0, 7));
      raddr_b = AW'($urandom_range(0, 7));
      wdata = DW'($urandom);
      cyc("rand");
    end
    idle();
    cyc("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
